// File: rtl/lab_two_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// lab_two_sweep_ctrl
//
// Purpose:
//   Drives a 4-input logic-under-test with ABCD vectors, holds each vector
//   for DWELL clocks and samples the KLMN response at dwell index SETTLE.
//   Each sample is compared with a 4-bit expected nibble taken from
//   exp_table. Mismatching vectors are counted and flagged in a mask.
//   Two run types are supported:
//     - mode=0: full sweep of vectors 0..15.
//     - mode=1: one vector taken from vec_in.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           run request, honoured only in IDLE (and only when abort=0)
//   abort           ends a run in APPLY on the next edge, without done
//   mode            0 = full sweep, 1 = single vector (latched on start)
//   vec_in[3:0]     single-mode vector (latched on start)
//   exp_table[63:0] expected KLMN, vector v uses bits [4v+3:4v]
//   klmn_in[3:0]    response of the logic under test {K,L,M,N}
//   abcd_out[3:0]   stimulus to the logic under test {A,B,C,D}
//   busy            high while in APPLY
//   done            one-cycle pulse on normal completion
//   cap_valid       one-cycle pulse qualifying cap_vec / cap_data
//   cap_vec[3:0]    vector applied when the sample was taken
//   cap_data[3:0]   sampled klmn_in
//   err_count[4:0]  mismatching vectors in the current or last run
//   fail_mask[15:0] bit v set when vector v mismatched
//   dbg_state_o     current FSM state (IDLE=0, APPLY=1, DONE=2)
//
// Handshake: start and abort are level requests sampled on every rising
// clk edge. cap_valid and done are single-cycle qualifiers with no
// back-pressure. The consumer must take cap_vec/cap_data in the cycle in
// which cap_valid is high.
// ---------------------------------------------------------------------------
module lab_two_sweep_ctrl #(
    parameter int DWELL  = 10,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [3:0]  vec_in,
    input  logic [63:0] exp_table,
    input  logic [3:0]  klmn_in,
    output logic [3:0]  abcd_out,
    output logic        busy,
    output logic        done,
    output logic        cap_valid,
    output logic [3:0]  cap_vec,
    output logic [3:0]  cap_data,
    output logic [4:0]  err_count,
    output logic [15:0] fail_mask,
    output logic [1:0]  dbg_state_o
);

    // Dwell counter width. It covers 0..DWELL-1.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [CW-1:0] LAST_C   = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     vec_q, vec_d;
    logic [CW-1:0]  dcnt_q, dcnt_d;
    logic           mode_q, mode_d;

    logic [3:0]     abcd_q, abcd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cap_valid_q, cap_valid_d;
    logic [3:0]     cap_vec_q, cap_vec_d;
    logic [3:0]     cap_data_q, cap_data_d;
    logic [4:0]     err_q, err_d;
    logic [15:0]    fail_q, fail_d;

    // Expected nibble for the vector currently applied.
    logic [3:0]     exp_nib;
    logic           sample_now;
    logic           last_dwell;
    logic           run_over;

    assign exp_nib    = exp_table[{vec_q, 2'b00} +: 4];
    assign sample_now = (dcnt_q == SETTLE_C);
    assign last_dwell = (dcnt_q == LAST_C);
    // A single-vector run ends after one dwell. A sweep ends after vector 15,
    // so the vector register never wraps.
    assign run_over   = mode_q || (vec_q == 4'd15);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dcnt_d      = dcnt_q;
        mode_d      = mode_q;
        cap_valid_d = 1'b0;
        cap_vec_d   = cap_vec_q;
        cap_data_d  = cap_data_q;
        err_d       = err_q;
        fail_d      = fail_q;

        unique case (state_q)
            IDLE: begin
                // start together with abort is deliberately not a request.
                if (start && !abort) begin
                    state_d = APPLY;
                    mode_d  = mode;
                    vec_d   = mode ? vec_in : 4'd0;
                    dcnt_d  = '0;
                    err_d   = 5'd0;
                    fail_d  = 16'h0000;
                end
            end

            APPLY: begin
                if (abort) begin
                    // abort beats a coincident sample. Results of the
                    // partial run stay visible.
                    state_d = IDLE;
                    vec_d   = 4'd0;
                    dcnt_d  = '0;
                end else begin
                    if (sample_now) begin
                        cap_valid_d = 1'b1;
                        cap_vec_d   = vec_q;
                        cap_data_d  = klmn_in;
                        if (klmn_in != exp_nib) begin
                            // At most 16 vectors per run, so the 5-bit
                            // count cannot overflow.
                            err_d  = err_q + 5'd1;
                            fail_d = fail_q | (16'h0001 << vec_q);
                        end
                    end

                    if (last_dwell) begin
                        dcnt_d = '0;
                        if (run_over) begin
                            state_d = DONE;
                            vec_d   = 4'd0;
                        end else begin
                            vec_d = vec_q + 4'd1;
                        end
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
            end

            DONE: begin
                // This state lasts one cycle. start is not looked at here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                vec_d   = 4'd0;
                dcnt_d  = '0;
            end
        endcase

        // Outputs are derived from the next state, so the registered copies
        // line up with the state they describe.
        busy_d = (state_d == APPLY);
        done_d = (state_d == DONE);
        abcd_d = (state_d == APPLY) ? vec_d : 4'd0;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= 4'd0;
            dcnt_q      <= '0;
            mode_q      <= 1'b0;
            abcd_q      <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_vec_q   <= 4'd0;
            cap_data_q  <= 4'd0;
            err_q       <= 5'd0;
            fail_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dcnt_q      <= dcnt_d;
            mode_q      <= mode_d;
            abcd_q      <= abcd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cap_valid_q <= cap_valid_d;
            cap_vec_q   <= cap_vec_d;
            cap_data_q  <= cap_data_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
        end
    end

    assign abcd_out    = abcd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cap_valid   = cap_valid_q;
    assign cap_vec     = cap_vec_q;
    assign cap_data    = cap_data_q;
    assign err_count   = err_q;
    assign fail_mask   = fail_q;
    assign dbg_state_o = state_q;

    // Structural invariants of the controller.
    a_err_bound: assert property (@(posedge clk) disable iff (!rst_n)
        err_q <= 5'd16);
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q == APPLY));
    a_done_state: assert property (@(posedge clk) disable iff (!rst_n)
        done_q == (state_q == DONE));

endmodule

// File: tb/tb_lab_two_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab_two_sweep_ctrl
//
// Bench for lab_two_sweep_ctrl with DWELL=10 and SETTLE=2.
// The logic under test is a random 16-entry lookup table (lut), and
// klmn_in = lut[abcd_out]. For every run the driver computes the expected
// response from the rules of a run:
//   - per busy cycle i, the applied vector is first + i/DWELL;
//   - a sample is taken when i%DWELL == SETTLE, unless the run ends in
//     that cycle;
//   - the error tally counts the vectors whose expected nibble differs
//     from lut.
// The expected values go into queues. A monitor on the falling edge pops
// and compares them whenever the DUT presents busy, cap_valid or done.
// ---------------------------------------------------------------------------
module tb_lab_two_sweep_ctrl;

    localparam int DWELL  = 10;
    localparam int SETTLE = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start, abort, mode;
    logic [3:0]  vec_in;
    logic [63:0] exp_table;
    logic [3:0]  klmn_in;
    logic [3:0]  abcd_out;
    logic        busy, done, cap_valid;
    logic [3:0]  cap_vec, cap_data;
    logic [4:0]  err_count;
    logic [15:0] fail_mask;
    logic [1:0]  dbg_state;

    logic [3:0]  lut [16];
    assign klmn_in = lut[abcd_out];

    lab_two_sweep_ctrl #(.DWELL(DWELL), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .vec_in      (vec_in),
        .exp_table   (exp_table),
        .klmn_in     (klmn_in),
        .abcd_out    (abcd_out),
        .busy        (busy),
        .done        (done),
        .cap_valid   (cap_valid),
        .cap_vec     (cap_vec),
        .cap_data    (cap_data),
        .err_count   (err_count),
        .fail_mask   (fail_mask),
        .dbg_state_o (dbg_state)
    );

    // Scoreboard
    int errors = 0;
    int checks = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  exp_q      [$];   // abcd_out per busy cycle
    logic [7:0]  exp_cap_q  [$];   // {cap_vec, cap_data}
    logic [20:0] exp_done_q [$];   // {err_count, fail_mask}

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output, value %0h (t=%0t)", name, act, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_abcd"},      32'(abcd_out),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_cap_valid"}, 32'(cap_valid), 32'd0);
        check({tag, "_cap_vec"},   32'(cap_vec),   32'd0);
        check({tag, "_cap_data"},  32'(cap_data),  32'd0);
        check({tag, "_err"},       32'(err_count), 32'd0);
        check({tag, "_fail"},      32'(fail_mask), 32'd0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (busy) begin
                if (exp_q.size() == 0) flag("busy_overrun", 32'(abcd_out));
                else check("abcd_out", 32'(abcd_out), 32'(exp_q.pop_front()));
            end else begin
                check("abcd_idle", 32'(abcd_out), 32'd0);
            end
            if (cap_valid) begin
                if (exp_cap_q.size() == 0) begin
                    flag("cap_unexpected", 32'({cap_vec, cap_data}));
                end else begin
                    logic [7:0] e;
                    e = exp_cap_q.pop_front();
                    check("cap_vec",  32'(cap_vec),  32'(e[7:4]));
                    check("cap_data", 32'(cap_data), 32'(e[3:0]));
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    flag("done_unexpected", 32'({err_count, fail_mask}));
                end else begin
                    logic [20:0] d;
                    d = exp_done_q.pop_front();
                    check("done_err",  32'(err_count), 32'(d[20:16]));
                    check("done_fail", 32'(fail_mask), 32'(d[15:0]));
                    check("done_busy", 32'(busy),      32'd0);
                end
            end
        end
    end

    // Reference helpers
    function automatic logic [3:0] exp_nib(input logic [3:0] v);
        return exp_table[{v, 2'b00} +: 4];
    endfunction

    // Expected table equals lut, except that nibbles whose bit is set in
    // inv_mask are inverted.
    task automatic build_table(input logic [15:0] inv_mask);
        for (int v = 0; v < 16; v++)
            exp_table[v*4 +: 4] = inv_mask[v] ? ~lut[v] : lut[v];
    endtask

    task automatic new_lut();
        for (int v = 0; v < 16; v++) lut[v] = 4'($urandom);
    endtask

    // Driver: one run.
    //   kill_kind: 0 = none, 1 = abort, 2 = asynchronous reset.
    //   kill_at:   busy-cycle index in which the kill happens.
    //   restart_at: busy-cycle index of an extra start pulse (-1 = none).
    task automatic do_run(input logic m, input logic [3:0] v, input int kill_kind,
                          input int kill_at, input int restart_at);
        int          len;
        int          e_err;
        logic [15:0] e_fail;
        logic [3:0]  first;
        logic [3:0]  cv;
        len    = m ? DWELL : 16 * DWELL;
        first  = m ? v : 4'd0;
        e_err  = 0;
        e_fail = 16'h0000;
        if (kill_kind != 0) len = kill_at + 1;
        for (int i = 0; i < len; i++) begin
            cv = first + 4'(i / DWELL);
            exp_q.push_back(cv);
            if ((i % DWELL == SETTLE) && !(kill_kind != 0 && i == kill_at)) begin
                exp_cap_q.push_back({cv, lut[cv]});
                if (exp_nib(cv) != lut[cv]) begin
                    e_err++;
                    e_fail[cv] = 1'b1;
                end
            end
        end
        if (kill_kind == 0) exp_done_q.push_back({5'(e_err), e_fail});

        @(negedge clk);
        start  = 1'b1;
        mode   = m;
        vec_in = v;
        @(negedge clk);
        vec_in = 4'($urandom);
        for (int idx = 0; idx < len + 4; idx++) begin
            start = (idx == restart_at);
            abort = (kill_kind == 1) && (idx == kill_at);
            if (kill_kind == 2 && idx == kill_at) begin
                #3 rst_n = 1'b0;
                #1 check_all_zero("reset_mid");
                #3 rst_n = 1'b1;
                e_err  = 0;
                e_fail = 16'h0000;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;

        check("run_busy_end",  32'(busy),      32'd0);
        check("run_err_held",  32'(err_count), 32'(e_err));
        check("run_fail_held", 32'(fail_mask), 32'(e_fail));
        check("abcd_q_left",   32'(exp_q.size()),      32'd0);
        check("cap_q_left",    32'(exp_cap_q.size()),  32'd0);
        check("done_q_left",   32'(exp_done_q.size()), 32'd0);
        exp_q.delete();
        exp_cap_q.delete();
        exp_done_q.delete();
    endtask

    task automatic idle_start_abort();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        mode  = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("start_abort_busy2", 32'(busy), 32'd0);
    endtask

    // Main sequence
    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        vec_in    = 4'd0;
        exp_table = 64'd0;
        new_lut();
        build_table(16'h0000);

        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        #10 rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Full sweep, no errors, ignored start pulse mid-run.
        do_run(1'b0, 4'd0, 0, 0, $urandom_range(1, 16 * DWELL - 2));
        // Single vector 0101.
        do_run(1'b1, 4'b0101, 0, 0, -1);
        // Single vector, start offered during DONE is ignored.
        do_run(1'b1, 4'($urandom), 0, 0, DWELL);
        // Vector 3 nibble inverted.
        build_table(16'h0008);
        do_run(1'b0, 4'd0, 0, 0, -1);
        // Abort while 0101 is applied, after its sample was taken.
        build_table(16'h0028);
        do_run(1'b1, 4'b0101, 1, $urandom_range(SETTLE + 1, DWELL - 1), -1);
        // Abort coincident with the sample of vector 5 in a sweep.
        do_run(1'b0, 4'd0, 1, 5 * DWELL + SETTLE, -1);
        // start together with abort in IDLE.
        idle_start_abort();
        idle_start_abort();
        // Reset while vector 9 is applied, then a fresh sweep.
        new_lut();
        build_table(16'h0401);
        do_run(1'b0, 4'd0, 2, 9 * DWELL + $urandom_range(0, DWELL - 1), -1);
        do_run(1'b0, 4'd0, 0, 0, -1);

        // Randomised runs.
        for (int r = 0; r < 8; r++) begin
            logic        rm;
            int          kind;
            int          full_len;
            int          kat;
            int          rst_at;
            rm = 1'($urandom);
            new_lut();
            build_table(16'($urandom) & 16'($urandom));
            full_len = rm ? DWELL : 16 * DWELL;
            kind     = $urandom_range(0, 2);
            kat      = $urandom_range(0, full_len - 1);
            rst_at   = (kind == 0) ? $urandom_range(0, full_len) : -1;
            do_run(rm, 4'($urandom), kind, kat, rst_at);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab_two_sweep_ctrl.md
LAB_TWO_SWEEP_CTRL -- requirements
Module: lab_two_sweep_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DWELL SHALL default to 10; it is the number of clk cycles each ABCD vector is held. Legal values are DWELL >= 2.
REQ-003 Parameter SETTLE SHALL default to 2; it is the dwell index at which KLMN is sampled. Legal values are 0 <= SETTLE < DWELL.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request to begin a run; sampled only in IDLE.
REQ-007 abort  in  1  terminates the current run.
REQ-008 mode  in  1  run type: 0 = full sweep of vectors 0..15; 1 = single vector taken from vec_in.
REQ-009 vec_in  in  4  single-mode vector, latched on an accepted start.
REQ-010 exp_table  in  64  expected KLMN; vector v uses bits [4v+3:4v].
REQ-011 klmn_in  in  4  logic-under-test outputs {K,L,M,N}, with K as MSB.
REQ-012 abcd_out  out  4  drive to the logic under test {A,B,C,D}, with A as MSB.
REQ-013 busy  out  1  high while in state APPLY.
REQ-014 done  out  1  one-cycle pulse marking normal completion.
REQ-015 cap_valid  out  1  one-cycle pulse qualifying cap_vec and cap_data.
REQ-016 cap_vec  out  4  vector that was applied when the sample was taken.
REQ-017 cap_data  out  4  sampled klmn_in.
REQ-018 err_count  out  5  number of mismatching vectors in the current or last run.
REQ-019 fail_mask  out  16  bit v is set if vector v mismatched.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, APPLY and DONE. All outputs SHALL be registered.
REQ-021 IDLE: start=1 with abort=0 SHALL move to APPLY and perform the following at that edge:
- load the vector register with 0 (mode=0) or vec_in (mode=1);
- set dwell counter dcnt = 0;
- clear err_count and fail_mask.
REQ-022 In APPLY, abcd_out SHALL equal the vector register; in IDLE and DONE, abcd_out SHALL be 0000.
REQ-023 In APPLY, dcnt SHALL increment by 1 every cycle, ranging over 0..DWELL-1.
REQ-024 At the edge where dcnt==SETTLE, the module SHALL:
- load cap_data from klmn_in and cap_vec from the vector register;
- assert cap_valid for the next cycle only.
REQ-025 At the same edge, if klmn_in differs from exp_table[4v+3:4v], the module SHALL increment err_count and set fail_mask[v].
REQ-026 At the edge where dcnt==DWELL-1, the module SHALL go to DONE if mode=1 or the vector is 15; otherwise it SHALL increment the vector, reset dcnt to 0 and stay in APPLY.
REQ-027 The vector SHALL never wrap past 15. A full run SHALL keep busy high for exactly 16*DWELL cycles; a single-vector run, for exactly DWELL cycles.
REQ-028 DONE SHALL last exactly one cycle with done=1 and then return to IDLE. start SHALL be ignored while in DONE.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in APPLY SHALL force IDLE on the next edge:
- abcd_out becomes 0000;
- done does not pulse;
- no further capture occurs;
- err_count and fail_mask keep their values.
REQ-031 If abort=1 and dcnt==SETTLE coincide, abort SHALL win and no capture or error update SHALL occur.
REQ-032 In IDLE, simultaneous start=1 and abort=1 SHALL be ignored (the module stays in IDLE).
REQ-033 err_count SHALL never exceed 16, so no saturation logic is required.

Reset
REQ-034 rst_n=0 SHALL immediately force the following, regardless of clk:
- state = IDLE; vector = 0; dcnt = 0;
- abcd_out = 0000; cap_vec = 0000; cap_data = 0000;
- busy = 0; done = 0; cap_valid = 0;
- err_count = 0; fail_mask = 0x0000.
REQ-035 Reset asserted mid-run SHALL discard the run without a done pulse. After release, the module SHALL wait for a new start.

Verification
REQ-036 Full sweep: DWELL=10, SETTLE=2, exp_table matching a behavioural model, mode=0 -> abcd_out steps 0..15 at 10 cycles each; 16 cap_valid pulses with cap_vec 0..15; busy high for 160 cycles; done high for 1 cycle; err_count=0; fail_mask=0x0000.
REQ-037 Single vector: mode=1, vec_in=0101 -> abcd_out=0101 for 10 cycles; one cap_valid with cap_vec=0101; done pulses; abcd_out returns to 0000.
REQ-038 Mismatch: the exp_table nibble for vector 3 is inverted -> err_count=1, fail_mask=0x0008; all other cap_data values match the model.
REQ-039 Abort: abort=1 while abcd_out=0101 -> next cycle busy=0 and abcd_out=0000; no done pulse; fail_mask and err_count are held.
REQ-040 Reset mid-sweep: rst_n=0 while vector=9 -> all outputs are 0 without waiting for a clock edge; a fresh start after release begins at vector 0.
REQ-041 Ignored requests:
- start pulsed during busy -> no effect, and the sweep completes at the original 160-cycle boundary;
- start=1 with abort=1 in IDLE -> busy stays 0.
